// File: rtl/uart_word_rx_pkg.sv
// Shared definitions for the UART word receiver: byte FSM encoding,
// board-clock defaults and the word-assembly helper.
package uart_word_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // 25 MHz board clock at 115200 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 217;
  localparam int unsigned DEFAULT_TIMEOUT_BITS = 16;

  function automatic logic [15:0] make_word(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte deserialiser: RX synchroniser, mid-bit timer and byte FSM.
// Emits registered byte_valid / frame_err pulses; busy_o is high outside IDLE.
module uart_rx_byte
  import uart_word_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

  rx_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        rx_meta_q, rx_s_q;
  logic        fall_s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  // rx_s is falling on this edge; entering START now keeps samples at mid-bit
  assign fall_s = rx_s_q & ~rx_meta_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall_s) begin
          state_d = ST_START;
          cnt_d   = HALF_CNT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rx_s_q) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          cnt_d     = FULL_CNT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = FULL_CNT;
          if (bit_idx_q == 3'd7) begin
            state_d   = ST_STOP;
            bit_idx_d = 3'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = ST_IDLE;
          if (rx_s_q) begin
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = err_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: rtl/uart_word_rx.sv
// Pairs received bytes low-then-high into 16-bit words for the Hack load path;
// a lone low byte is dropped after TIMEOUT_BITS idle bit-times.
module uart_word_rx
  import uart_word_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned TIMEOUT_BITS = DEFAULT_TIMEOUT_BITS
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RX,
  output logic [15:0] OUT,
  output logic        LOAD,
  output logic        ERR
);

  localparam int unsigned TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TW        = $clog2(TMO_LIMIT + 1);

  logic [7:0]    rx_byte_s;
  logic          byte_valid_s, frame_err_s, busy_s;
  logic [15:0]   out_q, out_d;
  logic          load_q, load_d;
  logic          err_q, err_d;
  logic          half_q, half_d;
  logic [7:0]    low_q, low_d;
  logic [TW-1:0] tmo_q, tmo_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .rx_i        (RX),
    .byte_o      (rx_byte_s),
    .byte_valid_o(byte_valid_s),
    .frame_err_o (frame_err_s),
    .busy_o      (busy_s)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_q  <= 16'h0000;
      load_q <= 1'b0;
      err_q  <= 1'b0;
      half_q <= 1'b0;
      low_q  <= 8'h00;
      tmo_q  <= '0;
    end else begin
      out_q  <= out_d;
      load_q <= load_d;
      err_q  <= err_d;
      half_q <= half_d;
      low_q  <= low_d;
      tmo_q  <= tmo_d;
    end
  end

  // Byte events take priority; the timeout only runs while the line is idle
  always_comb begin
    out_d  = out_q;
    load_d = 1'b0;
    err_d  = 1'b0;
    half_d = half_q;
    low_d  = low_q;
    tmo_d  = tmo_q;
    if (frame_err_s) begin
      err_d  = 1'b1;
      half_d = 1'b0;
      tmo_d  = '0;
    end else if (byte_valid_s) begin
      if (half_q) begin
        out_d  = make_word(rx_byte_s, low_q);
        load_d = 1'b1;
        half_d = 1'b0;
      end else begin
        low_d  = rx_byte_s;
        half_d = 1'b1;
      end
      tmo_d = '0;
    end else if (half_q && !busy_s) begin
      if (tmo_q == TW'(TMO_LIMIT - 1)) begin
        half_d = 1'b0;
        tmo_d  = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

  assign OUT  = out_q;
  assign LOAD = load_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx at 8 clocks per bit: reset, pairing,
// back-to-back frames, framing error, false start, timeout, mid-frame reset.
module tb_uart_word_rx;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        RESET;
  logic        RX;
  logic [15:0] OUT;
  logic        LOAD;
  logic        ERR;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int load_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int load_cyc = 0;
  int err_cyc  = 0;
  logic [15:0] words[$];

  uart_word_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(16)) dut (
    .CLK  (clk),
    .RESET(RESET),
    .RX   (RX),
    .OUT  (OUT),
    .LOAD (LOAD),
    .ERR  (ERR)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!RESET) begin
      if (LOAD) begin
        words.push_back(OUT);
        load_cnt = load_cnt + 1;
        load_cyc = cyc;
      end
      if (ERR) begin
        err_cnt = err_cnt + 1;
        err_cyc = cyc;
      end
      if (LOAD && ERR) both_cnt = both_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass = n_pass + 1;
  endtask

  // Caller is aligned #1 after a rising edge; returns aligned the same way.
  task automatic send_byte(input logic [7:0] d, input logic stop_bit, output int start_cyc);
    RX = 1'b0;
    start_cyc = cyc;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    RX = stop_bit;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] last_word();
    if (words.size() == 0) return 16'hxxxx;
    return words[words.size() - 1];
  endfunction

  int s;

  initial begin
    RX    = 1'b1;
    RESET = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", OUT, 16'h0000);
    check("rst_load", LOAD, 1'b0);
    check("rst_err", ERR, 1'b0);
    RESET = 1'b0;
    idle(40);
    check("idle_load", load_cnt, 0);
    check("idle_err", err_cnt, 0);

    // single word, 2-bit gap between bytes
    send_byte(8'h34, 1'b1, s);
    idle(2 * CPB);
    send_byte(8'h12, 1'b1, s);
    idle(10);
    check("sw_count", load_cnt, 1);
    check("sw_word", last_word(), 16'h1234);
    check("sw_latency", load_cyc - s, 79);

    // back-to-back, zero gap
    send_byte(8'hEF, 1'b1, s);
    send_byte(8'hBE, 1'b1, s);
    send_byte(8'hAD, 1'b1, s);
    send_byte(8'hDE, 1'b1, s);
    idle(10);
    check("b2b_count", load_cnt, 3);
    check("b2b_w0", words[1], 16'hBEEF);
    check("b2b_w1", words[2], 16'hDEAD);

    // framing error
    send_byte(8'h55, 1'b0, s);
    idle(2 * CPB);
    check("fe_err", err_cnt, 1);
    check("fe_latency", err_cyc - s, 79);
    check("fe_noload", load_cnt, 3);
    send_byte(8'h78, 1'b1, s);
    send_byte(8'h56, 1'b1, s);
    idle(10);
    check("fe_count", load_cnt, 4);
    check("fe_word", last_word(), 16'h5678);
    check("fe_err_once", err_cnt, 1);

    // false start: 3-cycle glitch
    RX = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(20);
    check("fs_err", err_cnt, 1);
    check("fs_load", load_cnt, 4);
    check("fs_idle", dut.u_byte.state_q, 2'd0);
    send_byte(8'h01, 1'b1, s);
    send_byte(8'h00, 1'b1, s);
    idle(10);
    check("fs_word", last_word(), 16'h0001);

    // timeout drops the pending low byte
    send_byte(8'hAA, 1'b1, s);
    idle(20 * CPB);
    send_byte(8'h22, 1'b1, s);
    send_byte(8'h11, 1'b1, s);
    idle(10);
    check("to_count", load_cnt, 6);
    check("to_word", last_word(), 16'h1122);

    // reset mid-frame with a pending low byte
    send_byte(8'h9A, 1'b1, s);
    RX = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    RESET = 1'b1;
    #1;
    check("mr_out", OUT, 16'h0000);
    check("mr_load", LOAD, 1'b0);
    check("mr_err", ERR, 1'b0);
    @(posedge clk);
    #1;
    RX = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    RESET = 1'b0;
    idle(40);
    check("mr_quiet", load_cnt + err_cnt, 6 + 1);
    send_byte(8'hCD, 1'b1, s);
    send_byte(8'hAB, 1'b1, s);
    idle(10);
    check("mr_count", load_cnt, 7);
    check("mr_word", last_word(), 16'hABCD);
    check("never_both", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
